// File: rtl/insight_tap_evt_pkg.sv
// Shared widths, record layout and event kinds for the Insight tap event capture.
package insight_tap_evt_pkg;

  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned TS_W    = 16;
  localparam int unsigned REC_W   = 31;

  typedef enum logic {
    EVT_CHANGE = 1'b0,
    EVT_SYNC   = 1'b1
  } evt_kind_e;

  typedef struct packed {
    logic               lost;
    evt_kind_e          kind;
    logic [TS_W-1:0]    ts;
    logic [FIELD_W-1:0] field;
    logic [FLAG_W-1:0]  flags;
  } evt_rec_t;

  function automatic evt_rec_t make_rec(input logic lost, input evt_kind_e kind,
                                        input logic [TS_W-1:0] ts,
                                        input logic [FIELD_W-1:0] field,
                                        input logic [FLAG_W-1:0] flags);
    evt_rec_t r;
    r.lost  = lost;
    r.kind  = kind;
    r.ts    = ts;
    r.field = field;
    r.flags = flags;
    return r;
  endfunction

endpackage

// File: rtl/insight_tap_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is read from registered storage.
module insight_tap_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 31
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; no reset needed because the head is masked while empty.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/insight_tap_event_capture.sv
// Samples the CSR data taps, emits timestamped change/sync records through a FIFO,
// and tracks records dropped on overflow.
module insight_tap_event_capture
  import insight_tap_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [FLAG_W-1:0]                tap_flags,
  input  logic [FIELD_W-1:0]               tap_field,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TS_W+FIELD_W+FLAG_W+1:0]   out_record,
  output logic [7:0]                       lost_count
);

  localparam int unsigned TAP_W = FIELD_W + FLAG_W;
  localparam int unsigned RW    = TS_W + TAP_W + 2;

  logic [TAP_W-1:0] s_cur;
  logic [TAP_W-1:0] s_prev;
  logic             enable_d;
  logic             primed;
  logic             wrap_pending;
  logic             lost_sticky;
  logic [TS_W-1:0]  ts;

  logic             rise;
  logic             capture;
  logic             full;
  logic             empty;
  logic             pop;
  logic             free;
  logic             change_evt;
  logic             sync_evt;
  logic             push;
  logic             drop;
  evt_kind_e        kind;
  logic [TS_W-1:0]  rec_ts;
  logic [RW-1:0]    push_data;

  // Capture is active from the cycle after the registered enable rise, so the
  // baseline record is compared while ts already reads 0.
  assign rise    = enable && !enable_d;
  assign capture = enable && enable_d;

  assign pop        = out_ready && !empty;
  assign free       = !full || pop;
  assign change_evt = capture && ((s_cur != s_prev) || !primed);
  // Sync markers are only attempted into a free slot, so they are never dropped.
  assign sync_evt   = capture && wrap_pending && !change_evt && free;
  assign push       = (change_evt && free) || sync_evt;
  assign drop       = change_evt && !free;
  assign out_valid  = !empty;

  // Record assembly; change records take priority over sync markers.
  always_comb begin
    kind      = change_evt ? EVT_CHANGE : EVT_SYNC;
    rec_ts    = change_evt ? ts : '0;
    push_data = {lost_sticky, kind, rec_ts, s_cur};
  end

  // Two-stage tap sampling for change detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_cur  <= '0;
      s_prev <= '0;
    end else begin
      s_cur  <= {tap_field, tap_flags};
      s_prev <= s_cur;
    end
  end

  // Enable edge tracking, priming and the free-running timestamp.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_d <= 1'b0;
      primed   <= 1'b0;
      ts       <= '0;
    end else begin
      enable_d <= enable;
      if (!enable)       primed <= 1'b0;
      else if (enable_d) primed <= 1'b1;
      if (rise)        ts <= '0;
      else if (enable) ts <= ts + 1'b1;
    end
  end

  // Pending sync marker, armed when the timestamp wraps; a fresh enable restarts time.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_pending <= 1'b0;
    end else if (rise) begin
      wrap_pending <= 1'b0;
    end else if (capture && (ts == '1)) begin
      wrap_pending <= 1'b1;
    end else if (sync_evt) begin
      wrap_pending <= 1'b0;
    end
  end

  // Overflow accounting: sticky lost marker and saturating drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lost_sticky <= 1'b0;
      lost_count  <= '0;
    end else if (rise) begin
      lost_sticky <= 1'b0;
      lost_count  <= '0;
    end else if (drop) begin
      lost_sticky <= 1'b1;
      if (lost_count != 8'hFF) lost_count <= lost_count + 8'd1;
    end else if (push) begin
      lost_sticky <= 1'b0;
    end
  end

  insight_tap_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (out_record),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_insight_tap_event_capture.sv
// Scoreboard bench for insight_tap_event_capture: stimulus queues expected records,
// a negedge monitor pops and compares on every accepted handshake.
module tb_insight_tap_event_capture;
  import insight_tap_evt_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [4:0]  tap_flags;
  logic [7:0]  tap_field;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_record;
  logic [7:0]  lost_count;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int unsigned c_base = 0;
  logic [30:0] rec_q[$];
  logic [30:0] exp_rec;

  insight_tap_event_capture #(
    .DEPTH (8),
    .TS_W  (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .tap_flags  (tap_flags),
    .tap_field  (tap_field),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_record (out_record),
    .lost_count (lost_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [30:0] mk(input logic lost, input logic sync, input int unsigned t,
                                     input logic [7:0] fld, input logic [4:0] fl);
    logic [15:0] t16;
    t16 = t[15:0];
    return make_rec(lost, sync ? EVT_SYNC : EVT_CHANGE, t16, fld, fl);
  endfunction

  // Expected change record for taps driven now: compared next cycle with ts = cyc - c_base.
  task automatic exp_change(input logic lost);
    rec_q.push_back(mk(lost, 1'b0, cyc - c_base, tap_field, tap_flags));
  endtask

  // Monitor: every accepted record must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (rec_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got %h want none", out_record);
      end else begin
        exp_rec = rec_q.pop_front();
        if (out_record !== exp_rec) begin
          errors++;
          $display("FAIL record got %h want %h", out_record, exp_rec);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    tap_flags = '0;
    tap_field = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("reset_valid",  32'(out_valid),  32'd0);
    check("reset_record", 32'(out_record), 32'd0);
    check("reset_lost",   32'(lost_count), 32'd0);

    // Baseline after reset with constant zero taps: exactly one record, ts=0.
    reset_n = 1'b1;
    c_base  = cyc;
    rec_q.push_back(mk(1'b0, 1'b0, 0, 8'h00, 5'b00000));
    repeat (10) tick();
    check("baseline_drained", 32'(rec_q.size()), 32'd0);

    // Single flag flip: out_valid two cycles after the input change.
    tap_flags = 5'b00100;
    exp_change(1'b0);
    tick();
    check("latency_c1_valid", 32'(out_valid), 32'd0);
    tick();
    check("latency_c2_valid", 32'(out_valid), 32'd1);
    repeat (4) tick();

    // Change every cycle with ready high: one record per cycle, nothing lost.
    for (int k = 0; k < 10; k++) begin
      tap_field = 8'(k + 1);
      exp_change(1'b0);
      tick();
    end
    repeat (5) tick();
    check("throughput_lost",    32'(lost_count),   32'd0);
    check("throughput_drained", 32'(rec_q.size()), 32'd0);

    // Overflow: 12 changes into an 8-deep FIFO with ready low.
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      tap_field = 8'(8'h20 + k);
      if (k < 8) exp_change(1'b0);
      tick();
    end
    repeat (3) tick();
    check("ovf_lost_count", 32'(lost_count), 32'd4);
    check("ovf_valid",      32'(out_valid),  32'd1);
    check("hold_head",      32'(out_record), 32'(rec_q[0]));
    tick();
    check("hold_stable",    32'(out_record), 32'(rec_q[0]));
    out_ready = 1'b1;
    repeat (12) tick();
    check("ovf_drained",    32'(rec_q.size()), 32'd0);
    check("ovf_lost_holds", 32'(lost_count),   32'd4);
    tap_field = 8'h5A;
    exp_change(1'b1);
    repeat (5) tick();
    check("lost_flag_drained", 32'(rec_q.size()), 32'd0);

    // Timestamp wrap with a change landing in the ts=0 cycle: change first, then sync.
    while (cyc != c_base + 65536) tick();
    tap_flags = 5'b01010;
    exp_change(1'b0);
    rec_q.push_back(mk(1'b0, 1'b1, 0, tap_field, tap_flags));
    repeat (6) tick();
    check("wrap_drained", 32'(rec_q.size()), 32'd0);

    // Reset mid-drain with 5 records queued.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tap_field = 8'(8'h60 + k);
      exp_change(1'b0);
      tick();
    end
    repeat (3) tick();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid",  32'(out_valid),  32'd0);
    check("async_reset_lost",   32'(lost_count), 32'd0);
    check("async_reset_record", 32'(out_record), 32'd0);
    rec_q.delete();
    tick();
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    c_base    = cyc;
    rec_q.push_back(mk(1'b0, 1'b0, 0, tap_field, tap_flags));
    repeat (6) tick();
    check("post_reset_baseline", 32'(rec_q.size()), 32'd0);

    // Enable dropped with records queued: they drain, later tap changes are ignored.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tap_field = 8'(8'h70 + k);
      exp_change(1'b0);
      tick();
    end
    repeat (2) tick();
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tap_field = 8'(8'h80 + k);
      tick();
    end
    out_ready = 1'b1;
    repeat (8) tick();
    check("disabled_drained", 32'(rec_q.size()), 32'd0);
    check("disabled_valid",   32'(out_valid),    32'd0);

    // Re-enable gives a fresh baseline at ts=0.
    enable = 1'b1;
    c_base = cyc;
    rec_q.push_back(mk(1'b0, 1'b0, 0, tap_field, tap_flags));
    repeat (6) tick();
    check("reenable_baseline", 32'(rec_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
